fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer for the RV32I core: owns the `next_pc` input of the `pc` register and drives the instruction-memory request handshake. It holds, advances or redirects the PC, buffers the fetched word until the core consumes it, and handles halt requests and misaligned-target traps. It sits between `pc`, instruction memory and the decode/execute stage, and counts retired instructions.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect target

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- pc_in  in  32  current PC from `pc.pc_out`
- next_pc  out  32  to `pc.next_pc`; combinational
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address (= pc_in)
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  buffered instruction to decode
- instr_valid  out  1  instr is valid, held until acked
- instr_ack  in  1  core consumes instr this cycle (retire)
- redirect_valid  in  1  taken branch/jump for the instruction being acked
- redirect_target  in  32  branch/jump target
- halt_req  in  1  request to stop fetching after current retire
- halted  out  1  controller parked in HALT
- misalign_trap  out  1  one-cycle pulse: redirect target misaligned
- instret  out  32  retired-instruction counter

## Operation
- FSM states: BOOT, FETCH, ISSUE, HALT.
- BOOT: entered by reset; next_pc = RESET_VECTOR; imem_req = 0; unconditional → FETCH.
- FETCH: imem_req = 1, imem_addr = pc_in, next_pc = pc_in (hold). On imem_ready: instr ← imem_rdata, instr_valid ← 1, → ISSUE.
- ISSUE: imem_req = 0; instr_valid = 1; next_pc = pc_in until instr_ack. On instr_ack: instret += 1 (wraps at 2^32); next_pc selected:
  - redirect_valid && redirect_target[1:0] == 0 → redirect_target
  - redirect_valid && redirect_target[1:0] != 0 → TRAP_VECTOR; misalign_trap pulses the next cycle
  - otherwise → pc_in + 4 (32-bit wrap, 32'hFFFF_FFFC → 0)
  - then instr_valid ← 0; → HALT if halt_req, else → FETCH.
- HALT: next_pc = pc_in; halted = 1; imem_req = 0; → FETCH when halt_req = 0.
- redirect_valid and halt_req are sampled only in ISSUE with instr_ack; ignored elsewhere.
- instr_ack outside ISSUE is ignored (no count, no PC change).
- halt_req while in FETCH: fetch completes and instruction is issued normally; halt takes effect on its ack.

## Timing
- Reset values: state BOOT, instr 32'h0000_0013 (NOP), instr_valid 0, halted 0, misalign_trap 0, instret 0; imem_req 0 by decode of BOOT.
- First edge after reset release: pc ← RESET_VECTOR; second cycle: FETCH with imem_addr = RESET_VECTOR.
- Minimum throughput with zero-wait memory and instr_ack held high: one instruction per 2 cycles (FETCH, ISSUE).
- imem_rdata captured on the same edge imem_ready is seen; instr_valid rises the cycle after.
- PC update occurs on the ack edge; the next FETCH presents the new address the following cycle.
- imem_req remains high across wait states; imem_addr must not change while imem_req = 1.
- misalign_trap: registered, high exactly one cycle following the ack edge.
- Reset mid-fetch: outstanding memory response is dropped; the FSM returns to BOOT immediately (asynchronous).

## Structure
- Package `fetch_pkg`: state enum `fetch_state_t` {BOOT, FETCH, ISSUE, HALT}, `INSTR_BYTES` = 4, `NOP_INSTR` = 32'h0000_0013.
- One sub-module is natural: `next_pc_sel`, a combinational mux computing next_pc and the misalign flag from state, pc_in, ack and redirect inputs. The FSM, instruction buffer and counter stay in `fetch_ctrl`.
- `pc` is instantiated beside it at the core level, not inside.

## Test plan
- Reset release, zero-wait memory, instr_ack always high → imem_addr 0x0, 0x4, 0x8 on successive FETCH cycles; instret = 3 after three ISSUE acks.
- imem_ready delayed 3 cycles → imem_req high with constant imem_addr for 4 cycles, next_pc = pc_in throughout, instr = imem_rdata only after ready.
- Ack with redirect_valid, target 0x0000_0040 → following fetch address 0x40, no trap.
- Ack with redirect target 0x0000_0042 → next fetch at 0x100, misalign_trap high exactly one cycle.
- halt_req during FETCH → current instruction issued and acked, then halted = 1 with pc held; deassert halt_req → fetch resumes at pc+4.
- Reset asserted while in ISSUE with pc = 0x20 → instr_valid, instret, halted clear immediately; first post-reset fetch at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the fetch sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = ST_BOOT,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        HALT  = ST_HALT
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_next_pc_sel.sv
// ============================================================================
// next_pc_sel : combinational next-PC mux and misaligned-target detect
// Rev 1.0
// ============================================================================
`default_nettype none

module next_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  fetch_state_t state,
    input  logic [31:0]  pc_in,
    input  logic         instr_ack,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    output logic [31:0]  next_pc,
    output logic         misalign
);

    always_comb begin
        next_pc  = pc_in;
        misalign = 1'b0;
        case (state)
            BOOT:  next_pc = RESET_VECTOR;
            FETCH: next_pc = pc_in;
            ISSUE: begin
                if (instr_ack) begin
                    if (redirect_valid) begin
                        if (redirect_target[1:0] == 2'b00) begin
                            next_pc = redirect_target;
                        end else begin
                            next_pc  = TRAP_VECTOR;
                            misalign = 1'b1;
                        end
                    end else begin
                        next_pc = pc_in + INSTR_BYTES;
                    end
                end
            end
            HALT:    next_pc = pc_in;
            default: next_pc = pc_in;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : RV32I fetch sequencer - PC control, imem handshake, instr buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign_trap,
    output logic [31:0] instret
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         misalign;
    logic         fetch_done;
    logic         retire;

    next_pc_sel #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_next_pc_sel (
        .state           (state),
        .pc_in           (pc_in),
        .instr_ack       (instr_ack),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .next_pc         (next_pc),
        .misalign        (misalign)
    );

    // pc_in only moves on BOOT or an ack edge, so the address is stable while requesting
    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc_in;
    assign halted     = (state == HALT);
    assign fetch_done = (state == FETCH) && imem_ready;
    assign retire     = (state == ISSUE) && instr_ack;

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (imem_ready) state_nxt = ISSUE;
            ISSUE:   if (instr_ack)  state_nxt = halt_req ? HALT : FETCH;
            HALT:    if (!halt_req)  state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= BOOT;
            instr         <= NOP_INSTR;
            instr_valid   <= 1'b0;
            misalign_trap <= 1'b0;
            instret       <= 32'd0;
        end else begin
            state         <= state_nxt;
            misalign_trap <= misalign;
            if (fetch_done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                instr_valid <= 1'b0;
                instret     <= instret + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: table of fetch/issue vectors with a scoreboard of fetched words,
// plus hand-written halt and mid-issue reset sequences. An external pc register is modelled here.
`default_nettype none

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        misalign_trap;
    logic [31:0] instret;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = 32'd0;
    logic [31:0] sb[$];

    fetch_ctrl #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ack       (instr_ack),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .halted          (halted),
        .misalign_trap   (misalign_trap),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    // Beside-the-core pc register; odd reset value so the BOOT load is observable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 32'hFFFF_FFF0;
        else       pc <= next_pc;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    typedef struct {
        int          wt;
        int          ad;
        logic        rv;
        logic [31:0] tg;
        logic [31:0] ea;
        logic        et;
    } vec_t;

    // One full fetch/issue/ack transaction; leaves the bench at the negedge after the ack edge
    task automatic do_instr(input int wt, input int ad, input logic rv, input logic [31:0] tg,
                            input logic hl, input logic [31:0] ea, input logic et);
        logic [31:0] en;
        logic [31:0] got;
        wait_req();
        chk("fetch_addr", imem_addr, ea);
        for (int k = 0; k <= wt; k++) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, ea);
            chk("next_pc_hold", next_pc, ea);
            if (k >= 1) chk("trap_clear", {31'd0, misalign_trap}, 32'd0);
            if (k < wt) begin
                imem_ready      = 1'b0;
                instr_ack       = 1'b1;
                redirect_valid  = 1'b1;
                redirect_target = 32'h0000_0200;
            end else begin
                imem_ready      = 1'b1;
                imem_rdata      = mem_word(ea);
                instr_ack       = 1'b0;
                redirect_valid  = 1'b0;
                sb.push_back(mem_word(ea));
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk("instr", instr, got);
        end
        for (int k = 0; k < ad; k++) begin
            chk("issue_hold_pc", next_pc, ea);
            @(negedge clk);
            chk("issue_hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        en = rv ? ((tg[1:0] == 2'b00) ? tg : 32'h0000_0100) : ea + 32'd4;
        instr_ack       = 1'b1;
        redirect_valid  = rv;
        redirect_target = tg;
        halt_req        = hl;
        #1;
        chk("next_pc_ack", next_pc, en);
        @(negedge clk);
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
        exp_instret    = exp_instret + 32'd1;
        chk("instret", instret, exp_instret);
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, et});
        chk("halted", {31'd0, halted}, {31'd0, hl});
        chk("valid_clear", {31'd0, instr_valid}, 32'd0);
        chk("pc_after_ack", pc, en);
        if (!hl) begin
            chk("req_next", {31'd0, imem_req}, 32'd1);
            chk("addr_next", imem_addr, en);
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{wt: 0, ad: 0, rv: 1'b0, tg: 32'h0,         ea: 32'h0000_0000, et: 1'b0};
        vecs[1] = '{wt: 0, ad: 0, rv: 1'b0, tg: 32'h0,         ea: 32'h0000_0004, et: 1'b0};
        vecs[2] = '{wt: 0, ad: 0, rv: 1'b0, tg: 32'h0,         ea: 32'h0000_0008, et: 1'b0};
        vecs[3] = '{wt: 3, ad: 1, rv: 1'b1, tg: 32'h0000_0040, ea: 32'h0000_000C, et: 1'b0};
        vecs[4] = '{wt: 0, ad: 0, rv: 1'b1, tg: 32'h0000_0042, ea: 32'h0000_0040, et: 1'b1};
        vecs[5] = '{wt: 1, ad: 0, rv: 1'b0, tg: 32'h0,         ea: 32'h0000_0100, et: 1'b0};
        vecs[6] = '{wt: 0, ad: 0, rv: 1'b1, tg: 32'hFFFF_FFFC, ea: 32'h0000_0104, et: 1'b0};
        vecs[7] = '{wt: 0, ad: 0, rv: 1'b0, tg: 32'h0,         ea: 32'hFFFF_FFFC, et: 1'b0};
        vecs[8] = '{wt: 0, ad: 0, rv: 1'b0, tg: 32'h0,         ea: 32'h0000_0000, et: 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_trap", {31'd0, misalign_trap}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_next_pc", next_pc, 32'h0000_0000);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_instr(vecs[i].wt, vecs[i].ad, vecs[i].rv, vecs[i].tg, 1'b0, vecs[i].ea, vecs[i].et);
        end

        // Halt requested while the fetch is still waiting on memory
        halt_req = 1'b1;
        do_instr(2, 0, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b0);
        for (int k = 0; k < 3; k++) begin
            instr_ack = 1'b1;
            chk("halt_held", {31'd0, halted}, 32'd1);
            chk("halt_req_low", {31'd0, imem_req}, 32'd0);
            chk("halt_next_pc", next_pc, 32'h0000_0008);
            chk("halt_pc", pc, 32'h0000_0008);
            chk("halt_instret", instret, exp_instret);
            @(negedge clk);
        end
        instr_ack = 1'b0;
        halt_req  = 1'b0;
        @(negedge clk);
        chk("resume_halted", {31'd0, halted}, 32'd0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h0000_0008);

        // Redirect to 0x20, then reset while that instruction sits in ISSUE
        do_instr(0, 0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0008, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = mem_word(32'h0000_0020);
        @(negedge clk);
        imem_ready = 1'b0;
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        chk("pre_rst_pc", pc, 32'h0000_0020);
        #2 reset = 1'b1;
        #1;
        exp_instret = 32'd0;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instret", instret, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_next_pc", next_pc, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0000_0000);
        do_instr(0, 0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
